// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 front end and core.
//   BLOCK_W / LEN_FIELD_W : block and length-field widths in bits
//   PAD_BYTE              : first padding byte (a single 1 bit followed by zeros)
//   SHA256_IV             : initial hash value H0..H7, H0 in the top word
//   pad_state_e           : message padder FSM states
//   pad_mode_e            : operation selected in the combinational block former
package sha256_pkg;

  localparam int unsigned BLOCK_W     = 512;
  localparam int unsigned LEN_FIELD_W = 64;
  localparam int unsigned BLOCK_BYTES = BLOCK_W / 8;
  // First byte index of the length field; padding at or beyond it needs an extra block.
  localparam int unsigned LEN_OFFSET  = BLOCK_BYTES - LEN_FIELD_W / 8;

  localparam logic [7:0] PAD_BYTE = 8'h80;

  localparam logic [255:0] SHA256_IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  typedef enum logic [2:0] {
    StFill,
    StPad,
    StIssue,
    StWait,
    StXpad
  } pad_state_e;

  typedef enum logic [1:0] {
    PadNone,       // block passes through untouched
    PadInBlock,    // 0x80 at p, zero tail, length field if it fits
    PadExtra80,    // extra block starting with 0x80
    PadExtraZero   // extra block of zeros
  } pad_mode_e;

endpackage

// File: rtl/sha256_pad_former.sv
// Combinational builder for padded SHA-256 blocks.
//   raw    : 64-byte buffer, byte 0 in the top bits
//   p      : byte index just after the final message byte (0..64)
//   mode   : padding operation to apply
//   bitlen : message length in bits
//   blk    : resulting 512-bit block
module sha256_pad_former
  import sha256_pkg::*;
#(
  parameter int unsigned LEN_W = 64
) (
  input  logic [BLOCK_W-1:0] raw,
  input  logic [6:0]         p,
  input  pad_mode_e          mode,
  input  logic [LEN_W-1:0]   bitlen,
  output logic [BLOCK_W-1:0] blk
);

  logic [LEN_FIELD_W-1:0] len_field;

  assign len_field = LEN_FIELD_W'(bitlen);

  always_comb begin
    blk = raw;
    unique case (mode)
      PadNone: blk = raw;
      PadInBlock: begin
        for (int i = 0; i < BLOCK_BYTES; i++) begin
          if (7'(i) == p) begin
            blk[BLOCK_W-1-8*i -: 8] = PAD_BYTE;
          end else if (7'(i) > p) begin
            blk[BLOCK_W-1-8*i -: 8] = 8'h00;
          end
        end
        // Length goes in only when 0x80 landed before the length field.
        if (p < 7'(LEN_OFFSET)) begin
          blk[LEN_FIELD_W-1:0] = len_field;
        end
      end
      PadExtra80:   blk = {PAD_BYTE, {(BLOCK_W-8-LEN_FIELD_W){1'b0}}, len_field};
      PadExtraZero: blk = {{(BLOCK_W-LEN_FIELD_W){1'b0}}, len_field};
      default:      blk = raw;
    endcase
  end

endmodule

// File: rtl/sha256_msg_padder.sv
// Byte-stream front end for the SHA-256 core: packs message bytes big-endian into
// 512-bit blocks, applies length padding and hands blocks to the core one at a time.
//   clk, rst_n                    : clock, asynchronous active-low reset
//   s_valid/s_ready/s_data/s_last : message byte stream in
//   blk_start                     : one-cycle pulse, blk_data/first/last valid with it
//   blk_data/blk_first/blk_last   : block and its position in the message, held until core_done
//   core_done                     : core absorbed the issued block
//   msg_done                      : pulse after the core absorbs the final block
//   busy                          : padder holds message state
module sha256_msg_padder
  import sha256_pkg::*;
#(
  parameter int unsigned LEN_W = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [7:0]         s_data,
  input  logic               s_last,
  output logic               blk_start,
  output logic [BLOCK_W-1:0] blk_data,
  output logic               blk_first,
  output logic               blk_last,
  input  logic               core_done,
  output logic               msg_done,
  output logic               busy
);

  pad_state_e         state_q, state_d;
  logic [6:0]         idx_q, idx_d;
  logic [LEN_W-1:0]   bitlen_q, bitlen_d;
  logic [BLOCK_W-1:0] buf_q, buf_d;
  logic               issued_q, issued_d;   // a block of this message has been issued
  logic               first_q, first_d;
  logic               last_q, last_d;
  logic               pend_x_q, pend_x_d;   // padding spilled, an extra block follows
  logic               pend_80_q, pend_80_d; // extra block must start with 0x80
  logic               msg_done_q, msg_done_d;

  pad_mode_e          pad_mode;
  logic [BLOCK_W-1:0] padded;

  sha256_pad_former #(
    .LEN_W (LEN_W)
  ) u_pad_former (
    .raw    (buf_q),
    .p      (idx_q),
    .mode   (pad_mode),
    .bitlen (bitlen_q),
    .blk    (padded)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    bitlen_d   = bitlen_q;
    buf_d      = buf_q;
    issued_d   = issued_q;
    first_d    = first_q;
    last_d     = last_q;
    pend_x_d   = pend_x_q;
    pend_80_d  = pend_80_q;
    msg_done_d = 1'b0;
    pad_mode   = PadNone;

    unique case (state_q)
      StFill: begin
        if (s_valid) begin
          // Byte i lives at bits [511-8i -: 8]; 63-i equals ~i over six bits.
          buf_d[{~idx_q[5:0], 3'b000} +: 8] = s_data;
          idx_d    = idx_q + 7'd1;
          bitlen_d = bitlen_q + LEN_W'(8);
          if (s_last) begin
            state_d = StPad;
          end else if (idx_q == 7'(BLOCK_BYTES - 1)) begin
            state_d = StIssue;
            first_d = ~issued_q;
            last_d  = 1'b0;
          end
        end
      end

      StPad: begin
        first_d = ~issued_q;
        state_d = StIssue;
        if (idx_q == 7'(BLOCK_BYTES)) begin
          pad_mode  = PadNone;
          last_d    = 1'b0;
          pend_x_d  = 1'b1;
          pend_80_d = 1'b1;
        end else if (idx_q < 7'(LEN_OFFSET)) begin
          pad_mode  = PadInBlock;
          last_d    = 1'b1;
        end else begin
          pad_mode  = PadInBlock;
          last_d    = 1'b0;
          pend_x_d  = 1'b1;
          pend_80_d = 1'b0;
        end
        buf_d = padded;
      end

      StIssue: begin
        issued_d = 1'b1;
        state_d  = StWait;
      end

      StWait: begin
        if (core_done) begin
          idx_d = '0;
          if (last_q) begin
            msg_done_d = 1'b1;
            bitlen_d   = '0;
            issued_d   = 1'b0;
            state_d    = StFill;
          end else if (pend_x_q) begin
            state_d = StXpad;
          end else begin
            state_d = StFill;
          end
        end
      end

      StXpad: begin
        pad_mode  = pend_80_q ? PadExtra80 : PadExtraZero;
        buf_d     = padded;
        first_d   = ~issued_q;
        last_d    = 1'b1;
        pend_x_d  = 1'b0;
        pend_80_d = 1'b0;
        state_d   = StIssue;
      end

      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StFill;
      idx_q      <= '0;
      bitlen_q   <= '0;
      buf_q      <= '0;
      issued_q   <= 1'b0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
      pend_x_q   <= 1'b0;
      pend_80_q  <= 1'b0;
      msg_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      bitlen_q   <= bitlen_d;
      buf_q      <= buf_d;
      issued_q   <= issued_d;
      first_q    <= first_d;
      last_q     <= last_d;
      pend_x_q   <= pend_x_d;
      pend_80_q  <= pend_80_d;
      msg_done_q <= msg_done_d;
    end
  end

  assign s_ready   = (state_q == StFill);
  assign blk_start = (state_q == StIssue);
  assign blk_data  = buf_q;
  assign blk_first = first_q;
  assign blk_last  = last_q;
  assign msg_done  = msg_done_q;
  assign busy      = ~((state_q == StFill) && (idx_q == 7'd0) && !issued_q);

endmodule

// File: doc/sha256_msg_padder.md
# sha256_msg_padder

Front-end feeder for the SHA-256 core. It accepts a message as a byte stream, packs the bytes big-endian into 512-bit blocks, and applies FIPS 180-4 padding: a 0x80 byte, zero fill, then the 64-bit message bit length. It issues each block to the core with a one-cycle start pulse and waits for the core's completion pulse before accepting more bytes. It is the producer end of the core's block interface.

## Interface
- LEN_W, 64, width of the message bit-length counter and of the length field.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- s_valid  in  1  input byte valid.
- s_ready  out  1  padder accepts a byte; transfer occurs when s_valid && s_ready.
- s_data  in  8  message byte.
- s_last  in  1  qualifies the final byte of the message.
- blk_start  out  1  one-cycle pulse; blk_data is valid in the same cycle.
- blk_data  out  512  block; byte 0 sits in [511:504], length field in [63:0].
- blk_first  out  1  block is the first of its message, so the core loads the IV.
- blk_last  out  1  block is the final block of its message.
- core_done  in  1  one-cycle pulse from the core: the issued block has been absorbed.
- msg_done  out  1  one-cycle pulse when core_done arrives for a blk_last block.
- busy  out  1  asserted in every state except FILL with byte index 0 and no message in progress.

## Operation
- States: FILL, PAD, ISSUE, WAIT, XPAD.
- **FILL:** s_ready=1. Each accepted byte is written at byte index idx (0..63); idx increments and bitlen increases by 8, modulo 2^LEN_W.
  - Non-last byte at idx 63: go to ISSUE with an unpadded block.
  - s_last byte: go to PAD.
- **PAD:** one cycle. p = index after the last byte.
  - p ≤ 55: write 0x80 at p, zeros up to byte 55, bitlen in [63:0]. Final block; go to ISSUE with blk_last=1.
  - 56 ≤ p ≤ 63: write 0x80 at p, zeros to byte 63. Go to ISSUE with blk_last=0 and pend_x=1 (extra block flag).
  - p = 64: block is already full. Go to ISSUE with blk_last=0, pend_x=1, pend_80=1.
- **ISSUE:** one cycle. blk_start=1. blk_first=1 if no earlier block of this message was issued. Go to WAIT.
- **WAIT:** s_ready=0. Stay until core_done.
  - If the block was blk_last: pulse msg_done, clear idx, bitlen and the first flag, go to FILL.
  - Else if pend_x: go to XPAD.
  - Else: go to FILL with idx=0.
- **XPAD:** one cycle. Build the extra block: byte 0 = 0x80 if pend_80, otherwise 0x00; zeros through byte 55; bitlen in [63:0]. Go to ISSUE with blk_last=1.
- core_done outside WAIT is ignored.
- An empty message is not supported: s_last always accompanies a data byte.
- Bit-length overflow past 2^LEN_W wraps silently, matching the spec limit.

## Timing
- Reset values:
  - state=FILL, idx=0, bitlen=0.
  - s_ready=1, blk_start=0, blk_data=0, blk_first=0, blk_last=0, msg_done=0, busy=0.
- Streaming rate: 1 byte/cycle in FILL.
- Latency, 64th non-last byte accepted to blk_start: 1 cycle.
- Latency, s_last byte accepted to blk_start: 2 cycles (PAD, then ISSUE).
- Latency, core_done to XPAD blk_start: 2 cycles.
- Latency, core_done to s_ready rising: 1 cycle.
- blk_data, blk_first and blk_last are held stable from ISSUE until core_done.
- Reset mid-operation: all state and flags clear asynchronously. The core side must be reset together with the padder.

## Structure
- Shared package sha256_pkg: BLOCK_W=512, LEN_FIELD_W=64, PAD_BYTE=8'h80, the padder state enum, and the IV constants also used by the core.
- Sub-module sha256_pad_former: combinational block builder. Inputs: raw 64-byte buffer, p, mode {none, in-block, extra-with-80, extra-zero}, bitlen. Output: padded 512-bit block.

## Test plan
- "abc" with s_last on 'c':
  - One block: 0x61626380, then zeros, length 0x18.
  - blk_first=blk_last=1. Core hash = ba7816bf…f20015ad. msg_done 1 cycle after core_done.
- 55-byte message: single block, 0x80 at byte 55, length 0x1B8.
- 56-byte message: two blocks.
  - Block 1 has 0x80 at byte 56, zero tail, blk_last=0.
  - Block 2 is all zero with length 0x1C0, blk_first=0, blk_last=1.
- 64-byte message: full data block, then an extra block with byte 0 = 0x80 and length 0x200.
- Backpressure:
  - Hold core_done off for 100 cycles: s_ready stays 0 and blk_data stays stable.
  - A spurious core_done in FILL has no effect.
  - Random s_valid gaps give identical blocks.
- Async reset asserted at byte 30: outputs return to reset values. A following "abc" produces the correct single block with blk_first=1.
